// File: rtl/dcp_pkg.sv
// Shared DCP definitions: ASCII codes, scan request types, scan states, command codes.
// No logic; constants and types only.
// Imported by the scanner, the decoder and the DCP/PRINT command blocks.
package dcp_pkg;

    // Separator characters recognised by the scanner
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Request type sampled from type_rx when a request starts
    localparam logic TYPE_CHAR = 1'b0;
    localparam logic TYPE_HEX  = 1'b1;

    // DCP command codes, shared by DCP and PRINT
    localparam logic [7:0] CMD_DUMP  = 8'h44; // 'D'
    localparam logic [7:0] CMD_MODIFY = 8'h4D; // 'M'
    localparam logic [7:0] CMD_GO    = 8'h47; // 'G'
    localparam logic [7:0] CMD_REG   = 8'h52; // 'R'
    localparam logic [7:0] CMD_HELP  = 8'h3F; // '?'

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHAR_WAIT = 3'd1,
        HEX_WAIT  = 3'd2,
        DONE      = 3'd3,
        RELEASE   = 3'd4
    } scan_state_e;

    // True for the whitespace characters that delimit tokens
    function automatic logic is_sep_byte(input logic [7:0] b);
        return (b == ASCII_SP) || (b == ASCII_CR) || (b == ASCII_LF);
    endfunction

endpackage

// File: rtl/ascii_hex_decode.sv
// Classifies one ASCII byte as hex digit / separator and yields its nibble value.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake.
module ascii_hex_decode
    import dcp_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic       is_hex_o,
    output logic       is_sep_o,
    output logic [3:0] nibble_o
);

    // '0'-'9' map straight from the low nibble; 'A'-'F'/'a'-'f' have low nibble 1..6, +9 gives 10..15
    always_comb begin
        is_hex_o = 1'b0;
        is_sep_o = is_sep_byte(byte_i);
        nibble_o = byte_i[3:0];
        if (byte_i >= 8'h30 && byte_i <= 8'h39) begin
            is_hex_o = 1'b1;
        end else if ((byte_i >= 8'h41 && byte_i <= 8'h46) ||
                     (byte_i >= 8'h61 && byte_i <= 8'h66)) begin
            is_hex_o = 1'b1;
            nibble_o = byte_i[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/dcp_scan.sv
// DCP input scanner: per request returns one command char or one hex argument (DCP_SCAN_ECHO_EN adds echo).
// Latency: ack_rx one cycle after the terminating byte is accepted.
// Backpressure: rdy_rx only in CHAR_WAIT/HEX_WAIT (and echo register empty when echo is built in).
module dcp_scan
    import dcp_pkg::*;
#(
    parameter int MAX_DIGITS = 8,
    parameter int W          = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   d_rx,
    input  logic         vld_rx,
    output logic         rdy_rx,
    input  logic         req_rx,
    input  logic         type_rx,
    output logic         ack_rx,
    output logic         flag_rx,
    output logic [W-1:0] din_rx,
    output logic [7:0]   echo_d,
    output logic         echo_vld,
    input  logic         echo_rdy
);

    localparam int             CW      = $clog2(MAX_DIGITS + 2);
    localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_DIGITS);
    localparam logic [CW-1:0]  CNT_SAT = CW'(MAX_DIGITS + 1);

    scan_state_e   state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [W-1:0]  din_q, din_d;
    logic          flag_q, flag_d;
    logic          echo_vld_q;
    logic [7:0]    echo_d_q;

    logic          is_hex, is_sep;
    logic [3:0]    nibble;
    logic          wait_st;
    logic          accept;

    ascii_hex_decode u_dec (
        .byte_i   (d_rx),
        .is_hex_o (is_hex),
        .is_sep_o (is_sep),
        .nibble_o (nibble)
    );

    assign wait_st = (state_q == CHAR_WAIT) || (state_q == HEX_WAIT);
`ifdef DCP_SCAN_ECHO_EN
    assign rdy_rx  = wait_st && !echo_vld_q;
`else
    assign rdy_rx  = wait_st;
`endif
    assign accept  = vld_rx && rdy_rx;
    assign ack_rx  = (state_q == DONE);
    assign din_rx  = din_q;
    assign flag_rx = flag_q;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            din_q   <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            din_q   <= din_d;
            flag_q  <= flag_d;
        end
    end

    // Next-state: request start, byte scanning, result publish and four-phase release
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        din_d   = din_q;
        flag_d  = flag_q;
        case (state_q)
            IDLE: begin
                if (req_rx) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = (type_rx == TYPE_HEX) ? HEX_WAIT : CHAR_WAIT;
                end
            end
            CHAR_WAIT: begin
                if (!req_rx) begin
                    state_d = IDLE;
                end else if (accept && !is_sep) begin
                    din_d   = {{(W-8){1'b0}}, d_rx};
                    flag_d  = 1'b0;
                    state_d = DONE;
                end
            end
            HEX_WAIT: begin
                if (!req_rx) begin
                    state_d = IDLE;
                end else if (accept) begin
                    if (is_hex) begin
                        acc_d = {acc_q[W-5:0], nibble};
                        if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
                    end else if (is_sep) begin
                        // Leading separators are skipped until a digit has been seen
                        if (cnt_q != '0) begin
                            din_d   = acc_q;
                            flag_d  = (cnt_q > CNT_MAX) || err_q;
                            state_d = DONE;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DONE:    state_d = RELEASE;
            RELEASE: if (!req_rx) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef DCP_SCAN_ECHO_EN
    // One-entry echo buffer: filled by every accepted byte, drained by the transmitter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_vld_q <= 1'b0;
            echo_d_q   <= 8'h00;
        end else if (accept) begin
            echo_vld_q <= 1'b1;
            echo_d_q   <= d_rx;
        end else if (echo_vld_q && echo_rdy) begin
            echo_vld_q <= 1'b0;
        end
    end
`else
    logic unused_echo_rdy;
    assign unused_echo_rdy = echo_rdy;
    assign echo_vld_q      = 1'b0;
    assign echo_d_q        = 8'h00;
`endif

    assign echo_vld = echo_vld_q;
    assign echo_d   = echo_d_q;

endmodule
